// File: rtl/sar_pkg.sv
// Shared types and limits for the SAR conversion sequencer.
package sar_pkg;

  localparam int SAR_MAX_AVG_LOG2 = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_STROBE,
    S_DECIDE,
    S_ACC,
    S_DONE
  } sar_state_t;

endpackage

// File: rtl/sar_avg_accum.sv
// Oversampling accumulator: sums per-conversion codes, counts conversions
// and presents the truncated mean of the summed codes.
module sar_avg_accum
  import sar_pkg::*;
#(
  parameter int NBITS     = 8,
  parameter int NAVG_LOG2 = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             add_i,
  input  logic [NBITS-1:0] code_i,
  output logic             last_o,
  output logic [NBITS-1:0] avg_o
);

  localparam int AW = NBITS + NAVG_LOG2;
  localparam int CW = SAR_MAX_AVG_LOG2 + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'((1 << NAVG_LOG2) - 1);

  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (add_i) begin
      acc_d = acc_q + AW'(code_i);
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  // last_o is sampled while the final add is in flight, so it tests the pre-add count.
  assign last_o = (cnt_q == LAST_CNT);
  assign avg_o  = NBITS'(acc_q >> NAVG_LOG2);

endmodule

// File: rtl/sar_controller.sv
// SAR conversion sequencer: sample, MSB-first binary search with strobed
// comparator decisions, optional oversampling average, one result per start.
module sar_controller
  import sar_pkg::*;
#(
  parameter int NBITS     = 8,
  parameter int NSAMPLE   = 2,
  parameter int NAVG_LOG2 = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  output logic             ready,
  output logic [NBITS-1:0] data,
  output logic             data_valid,
  output logic             cmp_err,
  output logic             ms_sar_clock,
  output logic             ms_sar_sample,
  output logic [NBITS-1:0] ms_sar_sw,
  output logic [NBITS-1:0] ms_sar_swb,
  input  logic             ms_sar_dh,
  input  logic             ms_sar_dl,
  input  logic             ms_sar_rdy
);

  localparam int BW  = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int SMW = (NSAMPLE > 1) ? $clog2(NSAMPLE) : 1;
  localparam logic [NBITS-1:0] MSB_BIT = NBITS'(1) << (NBITS - 1);

  sar_state_t       state_q;
  logic             ready_q, valid_q, err_q, sclk_q, sample_q;
  logic [NBITS-1:0] data_q, sw_q, swb_q, code_q;
  logic [BW-1:0]    bit_q, bit_m1;
  logic [SMW-1:0]   smp_q;
  logic [NBITS-1:0] code_d, trial_d;
  logic             keep, acc_clear, acc_add, acc_last;
  logic [NBITS-1:0] acc_avg;

  // sw_q holds the current trial during DECIDE, so keeping the bit means adopting sw_q.
  always_comb begin
    keep    = ms_sar_dl & ~ms_sar_dh;
    code_d  = keep ? sw_q : code_q;
    bit_m1  = bit_q - BW'(1);
    trial_d = code_d | (NBITS'(1) << bit_m1);
  end

  assign acc_clear = (state_q == S_IDLE) && start && ready_q;
  assign acc_add   = (state_q == S_ACC);

  sar_avg_accum #(
    .NBITS    (NBITS),
    .NAVG_LOG2(NAVG_LOG2)
  ) u_avg (
    .clock  (clock),
    .reset  (reset),
    .clear_i(acc_clear),
    .add_i  (acc_add),
    .code_i (code_q),
    .last_o (acc_last),
    .avg_o  (acc_avg)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      sclk_q   <= 1'b0;
      sample_q <= 1'b0;
      data_q   <= '0;
      sw_q     <= '0;
      swb_q    <= '1;
      code_q   <= '0;
      bit_q    <= '0;
      smp_q    <= '0;
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start && ready_q) begin
            state_q  <= S_SAMPLE;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            sample_q <= 1'b1;
            smp_q    <= SMW'(NSAMPLE - 1);
          end else begin
            ready_q <= ms_sar_rdy;
          end
        end
        S_SAMPLE: begin
          if (smp_q == '0) begin
            state_q  <= S_STROBE;
            sample_q <= 1'b0;
            code_q   <= '0;
            bit_q    <= BW'(NBITS - 1);
            sw_q     <= MSB_BIT;
            swb_q    <= ~MSB_BIT;
            sclk_q   <= 1'b1;
          end else begin
            smp_q <= smp_q - SMW'(1);
          end
        end
        S_STROBE: begin
          state_q <= S_DECIDE;
          sclk_q  <= 1'b0;
        end
        S_DECIDE: begin
          code_q <= code_d;
          if (ms_sar_dh == ms_sar_dl) err_q <= 1'b1;
          if (bit_q == '0) begin
            state_q <= S_ACC;
          end else begin
            state_q <= S_STROBE;
            bit_q   <= bit_m1;
            sw_q    <= trial_d;
            swb_q   <= ~trial_d;
            sclk_q  <= 1'b1;
          end
        end
        S_ACC: begin
          sw_q  <= '0;
          swb_q <= '1;
          if (acc_last) begin
            state_q <= S_DONE;
          end else begin
            state_q  <= S_SAMPLE;
            sample_q <= 1'b1;
            smp_q    <= SMW'(NSAMPLE - 1);
          end
        end
        S_DONE: begin
          data_q  <= acc_avg;
          valid_q <= 1'b1;
          ready_q <= ms_sar_rdy;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ready         = ready_q;
  assign data          = data_q;
  assign data_valid    = valid_q;
  assign cmp_err       = err_q;
  assign ms_sar_clock  = sclk_q;
  assign ms_sar_sample = sample_q;
  assign ms_sar_sw     = sw_q;
  assign ms_sar_swb    = swb_q;

  a_sw_excl: assert property (@(posedge clock) (ms_sar_sw & ms_sar_swb) == '0);

endmodule

// File: tb/tb_sar_controller.sv
// Bench for sar_controller: two instances (plain and 4x averaging), a delayed
// behavioural comparator per instance, and a queue-based scoreboard.
module tb_sar_controller;

  localparam int LAT0 = 1 * (2 + 16 + 1) + 1;
  localparam int LAT1 = 4 * (3 + 16 + 1) + 1;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic       start0 = 1'b0, rdy0 = 1'b1, dh0 = 1'b0, dl0 = 1'b0;
  logic       ready0, dv0, err0, sclk0, samp0;
  logic [7:0] data0, sw0, swb0;
  logic       start1 = 1'b0, rdy1 = 1'b1, dh1 = 1'b0, dl1 = 1'b0;
  logic       ready1, dv1, err1, sclk1, samp1;
  logic [7:0] data1, sw1, swb1;

  sar_controller #(.NBITS(8), .NSAMPLE(2), .NAVG_LOG2(0)) u_dut0 (
    .clock(clock), .reset(reset), .start(start0), .ready(ready0),
    .data(data0), .data_valid(dv0), .cmp_err(err0),
    .ms_sar_clock(sclk0), .ms_sar_sample(samp0), .ms_sar_sw(sw0), .ms_sar_swb(swb0),
    .ms_sar_dh(dh0), .ms_sar_dl(dl0), .ms_sar_rdy(rdy0)
  );

  sar_controller #(.NBITS(8), .NSAMPLE(3), .NAVG_LOG2(2)) u_dut1 (
    .clock(clock), .reset(reset), .start(start1), .ready(ready1),
    .data(data1), .data_valid(dv1), .cmp_err(err1),
    .ms_sar_clock(sclk1), .ms_sar_sample(samp1), .ms_sar_sw(sw1), .ms_sar_swb(swb1),
    .ms_sar_dh(dh1), .ms_sar_dl(dl1), .ms_sar_rdy(rdy1)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [7:0] exp0_q[$], exp1_q[$];
  logic [7:0] tr0_q[$], tr1_q[$];
  logic [7:0] tg0_q[$], tg1_q[$];
  int         lat0_q[$], lat1_q[$];
  bit         force_b3 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference model: successive approximation as a plain loop; records the trial codes.
  task automatic expect_conv(input int inst, input logic [7:0] tg, input bit f3,
                             output logic [7:0] code);
    logic [7:0] t;
    code = 8'h00;
    for (int k = 7; k >= 0; k--) begin
      t = code | (8'h01 << k);
      if (inst == 0) tr0_q.push_back(t); else tr1_q.push_back(t);
      if (!(f3 && k == 3) && t <= tg) code = t;
    end
    if (inst == 0) tg0_q.push_back(tg); else tg1_q.push_back(tg);
  endtask

  // ---------------- behavioural comparators (one cycle after strobe) ----------------
  logic [7:0] t0, t1, cur_tg0 = 8'h00, cur_tg1 = 8'h00;

  always begin
    @(negedge clock);
    if (sclk0) begin
      t0 = sw0;
      if (t0 == 8'h80 && tg0_q.size() > 0) cur_tg0 = tg0_q.pop_front();
      @(posedge clock);
      #1;
      if (force_b3 && t0[3] && t0[2:0] == 3'b000) begin
        dl0 = 1'b0;
        dh0 = 1'b0;
      end else begin
        dl0 = (t0 <= cur_tg0);
        dh0 = !(t0 <= cur_tg0);
      end
    end
  end

  always begin
    @(negedge clock);
    if (sclk1) begin
      t1 = sw1;
      if (t1 == 8'h80 && tg1_q.size() > 0) cur_tg1 = tg1_q.pop_front();
      @(posedge clock);
      #1;
      dl1 = (t1 <= cur_tg1);
      dh1 = !(t1 <= cur_tg1);
    end
  end

  // ---------------- monitors ----------------
  logic [7:0] m0_e, m0_eb, m1_e, m1_eb;

  always @(negedge clock) begin
    check("excl0", sw0 & swb0, 0);
    if (sclk0) begin
      if (tr0_q.size() == 0) fail("unexpected_strobe0");
      else begin
        m0_e  = tr0_q.pop_front();
        m0_eb = ~m0_e;
        check("trial_sw0", sw0, m0_e);
        check("trial_swb0", swb0, m0_eb);
      end
    end
    if (dv0) begin
      if (exp0_q.size() == 0) fail("unexpected_valid0");
      else begin
        check("data0", data0, exp0_q.pop_front());
        check("latency0", cyc, lat0_q.pop_front());
      end
    end
  end

  always @(negedge clock) begin
    check("excl1", sw1 & swb1, 0);
    if (sclk1) begin
      if (tr1_q.size() == 0) fail("unexpected_strobe1");
      else begin
        m1_e  = tr1_q.pop_front();
        m1_eb = ~m1_e;
        check("trial_sw1", sw1, m1_e);
        check("trial_swb1", swb1, m1_eb);
      end
    end
    if (dv1) begin
      if (exp1_q.size() == 0) fail("unexpected_valid1");
      else begin
        check("data1", data1, exp1_q.pop_front());
        check("latency1", cyc, lat1_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue0(input logic [7:0] tg, input bit f3);
    logic [7:0] code;
    int n;
    n = 0;
    @(negedge clock);
    while (!ready0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!ready0) begin
      fail("ready0_timeout");
      return;
    end
    expect_conv(0, tg, f3, code);
    exp0_q.push_back(f3 ? code : tg);
    start0 = 1'b1;
    @(posedge clock);
    #1;
    start0 = 1'b0;
    lat0_q.push_back(cyc + LAT0);
  endtask

  task automatic issue1(input logic [3:0][7:0] tg);
    logic [7:0] code;
    int sum, n;
    sum = 0;
    n = 0;
    @(negedge clock);
    while (!ready1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (!ready1) begin
      fail("ready1_timeout");
      return;
    end
    for (int i = 0; i < 4; i++) begin
      expect_conv(1, tg[i], 1'b0, code);
      sum += int'(tg[i]);
    end
    exp1_q.push_back(8'(sum / 4));
    start1 = 1'b1;
    @(posedge clock);
    #1;
    start1 = 1'b0;
    lat1_q.push_back(cyc + LAT1);
  endtask

  task automatic wait_done0();
    int n;
    n = 0;
    while (exp0_q.size() != 0 && n < 400) begin
      @(negedge clock);
      n++;
    end
    if (exp0_q.size() != 0) fail("done0_timeout");
  endtask

  task automatic wait_done1();
    int n;
    n = 0;
    while (exp1_q.size() != 0 && n < 400) begin
      @(negedge clock);
      n++;
    end
    if (exp1_q.size() != 0) fail("done1_timeout");
  endtask

  task automatic check_reset0(input string tag);
    check({tag, "_ready"}, ready0, 0);
    check({tag, "_data"}, data0, 0);
    check({tag, "_valid"}, dv0, 0);
    check({tag, "_cmp_err"}, err0, 0);
    check({tag, "_sclk"}, sclk0, 0);
    check({tag, "_sample"}, samp0, 0);
    check({tag, "_sw"}, sw0, 8'h00);
    check({tag, "_swb"}, swb0, 8'hFF);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset0("rst0");
    check("rst1_ready", ready1, 0);
    check("rst1_swb", swb1, 8'hFF);
    reset = 1'b0;
    @(negedge clock);
    check("post_rst_ready0", ready0, 1);
    check("post_rst_ready1", ready1, 1);

    // Directed values, including both ends of the code range.
    issue0(8'hA5, 1'b0);
    wait_done0();
    issue0(8'h00, 1'b0);
    issue0(8'hFF, 1'b0);
    wait_done0();
    check("err_clean", err0, 0);

    // Averaging: 10+11+12+13 = 46, 46>>2 = 11.
    issue1({8'd13, 8'd12, 8'd11, 8'd10});
    wait_done1();

    // Comparator indecision on bit 3.
    force_b3 = 1'b1;
    issue0(8'hFF, 1'b1);
    wait_done0();
    force_b3 = 1'b0;
    check("err_set", err0, 1);
    repeat (5) @(negedge clock);
    check("err_sticky", err0, 1);
    issue0(8'h3C, 1'b0);
    check("err_clear_on_start", err0, 0);
    wait_done0();

    // Start while busy is ignored.
    issue0(8'h5A, 1'b0);
    repeat (6) @(negedge clock);
    check("busy_ready0", ready0, 0);
    start0 = 1'b1;
    @(negedge clock);
    start0 = 1'b0;
    wait_done0();
    repeat (25) @(negedge clock);
    check("no_extra_sample", samp0, 0);

    // Start with the front end not ready is ignored.
    rdy0 = 1'b0;
    repeat (2) @(negedge clock);
    check("rdy_low_ready0", ready0, 0);
    start0 = 1'b1;
    @(negedge clock);
    start0 = 1'b0;
    repeat (3) @(negedge clock);
    check("rdy_low_no_sample", samp0, 0);
    rdy0 = 1'b1;
    @(negedge clock);
    check("rdy_back_ready0", ready0, 1);

    // Front end drops mid-conversion: result still delivered, ready held low.
    issue0(8'h33, 1'b0);
    repeat (5) @(negedge clock);
    rdy0 = 1'b0;
    wait_done0();
    repeat (2) @(negedge clock);
    check("rdy_drop_ready0", ready0, 0);
    rdy0 = 1'b1;
    @(negedge clock);
    check("rdy_drop_recover", ready0, 1);

    // Randomized traffic on both instances concurrently.
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clock);
          issue0(8'($urandom_range(0, 255)), 1'b0);
        end
      end
      begin
        for (int j = 0; j < 3; j++) begin
          issue1({8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))});
        end
      end
    join
    wait_done0();
    wait_done1();

    // Reset in the middle of a conversion.
    issue0(8'h77, 1'b0);
    repeat (8) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    exp0_q.delete();
    lat0_q.delete();
    tr0_q.delete();
    tg0_q.delete();
    @(negedge clock);
    check_reset0("mid_rst0");
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("mid_rst_ready0", ready0, 1);
    repeat (30) @(negedge clock);
    check("mid_rst_idle_sample", samp0, 0);

    issue0(8'h96, 1'b0);
    wait_done0();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    fail("watchdog");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "bench timeout");
  end

endmodule
